// File: rtl/s_axi_reg_pkg.sv
// Shared widths, response codes and byte-strobe helper
// for the s_axi_reg register block.
package s_axi_reg_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/s_axi_reg_file.sv
// NUM_REGS x 32 register array: one byte-strobed write port,
// one combinational read port that sees pre-write contents.
module s_axi_reg_file
  import s_axi_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[widx_i] = strb_merge(mem_q[widx_i], wdata_i, wstrb_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/s_axi_reg.sv
// AXI4-Lite-style slave register file with single-entry
// AW/W buffers, one outstanding B and one outstanding R.
module s_axi_reg
  import s_axi_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int ADDR_LSB = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [31:0]       awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [31:0]       araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              rready_i
);

  // active_q keeps every ready low until the first edge after reset
  logic              active_q, active_d;
  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs;
  logic              b_hs, r_hs, commit;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rf_rdata;

  logic unused_ok;
  assign unused_ok = ^{awid_i, arid_i, awaddr_i, araddr_i};

  assign awready_o = active_q & ~aw_full_q;
  assign wready_o  = active_q & ~w_full_q;
  assign arready_o = active_q & ~rvalid_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = RESP_OKAY;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;

  assign aw_hs  = awvalid_i & awready_o;
  assign w_hs   = wvalid_i & wready_o;
  assign ar_hs  = arvalid_i & arready_o;
  assign b_hs   = bvalid_q & bready_i;
  assign r_hs   = rvalid_q & rready_i;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = araddr_i[ADDR_LSB +: IDX_W];

  s_axi_reg_file #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_file (
    .clk     (clk),
    .areset  (areset),
    .we_i    (commit),
    .widx_i  (aw_idx_q),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .ridx_i  (ar_idx),
    .rdata_o (rf_rdata)
  );

  always_comb begin
    active_d  = 1'b1;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr_i[ADDR_LSB +: IDX_W];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    // rf_rdata is the pre-commit value, so same-edge reads see old data
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rf_rdata;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      active_q  <= 1'b0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      active_q  <= active_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_s_axi_reg.sv
// Self-checking bench for s_axi_reg: directed channel scenarios
// plus random traffic against an array reference model.
module tb_s_axi_reg;
  import s_axi_reg_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid_i, arid_i;
  logic [31:0] awaddr_i, araddr_i, wdata_i;
  logic [3:0]  wstrb_i;
  logic        awvalid_i, wvalid_i, bready_i;
  logic        arvalid_i, rready_i;
  logic        awready_o, wready_o, bvalid_o;
  logic        arready_o, rvalid_o;
  logic [1:0]  bresp_o;
  logic [31:0] rdata_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mdl [N];

  always #5 clk = ~clk;

  s_axi_reg dut (
    .clk       (clk),
    .areset    (areset),
    .awid_i    (awid_i),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .arid_i    (arid_i),
    .araddr_i  (araddr_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .rready_i  (rready_i)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic b_resp(input string tag);
    int t = 0;
    while (!bvalid_o && t < 20) begin
      step();
      t++;
    end
    check({tag, "_bvalid"}, bvalid_o, 1);
    check({tag, "_bresp"}, bresp_o, RESP_OKAY);
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    logic a, w;
    awaddr_i = addr;
    wdata_i = data;
    wstrb_i = strb;
    awvalid_i = 1'b1;
    wvalid_i = 1'b1;
    while ((awvalid_i || wvalid_i) && t < 50) begin
      a = awvalid_i && awready_o;
      w = wvalid_i && wready_o;
      step();
      t++;
      if (a) awvalid_i = 1'b0;
      if (w) wvalid_i = 1'b0;
    end
    if (awvalid_i || wvalid_i) begin
      check({tag, "_aw_w_timeout"}, {awvalid_i, wvalid_i}, 0);
      awvalid_i = 1'b0;
      wvalid_i = 1'b0;
    end
    mdl[addr[3:0]] = merge(mdl[addr[3:0]], data, strb);
    b_resp(tag);
  endtask

  task automatic axi_read(input logic [31:0] addr,
                          output logic [31:0] data);
    int t = 0;
    araddr_i = addr;
    arvalid_i = 1'b1;
    while (!arready_o && t < 20) begin
      step();
      t++;
    end
    step();
    arvalid_i = 1'b0;
    check("rvalid_latency", rvalid_o, 1);
    data = rdata_o;
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, mdl[addr[3:0]]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, old;
    areset = 1'b0;
    awid_i = '0;
    arid_i = '0;
    awaddr_i = '0;
    araddr_i = '0;
    wdata_i = '0;
    wstrb_i = '0;
    awvalid_i = 1'b0;
    wvalid_i = 1'b0;
    bready_i = 1'b0;
    arvalid_i = 1'b0;
    rready_i = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;

    // reset
    repeat (4) step();
    check("rst_awready", awready_o, 0);
    check("rst_wready", wready_o, 0);
    check("rst_arready", arready_o, 0);
    check("rst_bvalid", bvalid_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_bresp", bresp_o, 0);
    areset = 1'b1;
    step();
    check("rel_awready", awready_o, 1);
    check("rel_wready", wready_o, 1);
    check("rel_arready", arready_o, 1);
    check("rel_bvalid", bvalid_o, 0);
    check("rel_rvalid", rvalid_o, 0);

    // data before address, extra data pulse ignored
    wdata_i = 32'hC2CCEE2E;
    wstrb_i = 4'hF;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    check("dfirst_wready", wready_o, 0);
    wdata_i = 32'hA3DDDD3F;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    check("dfirst_nocommit", bvalid_o, 0);
    awaddr_i = 32'hA3DD0000;
    awvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    check("dfirst_bv_pre", bvalid_o, 0);
    step();
    check("dfirst_bvalid", bvalid_o, 1);
    check("dfirst_bresp", bresp_o, RESP_OKAY);
    check("dfirst_awready", awready_o, 1);
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
    check("dfirst_bclr", bvalid_o, 0);
    mdl[0] = 32'hC2CCEE2E;
    read_chk("dfirst_reg0", 32'hA3DD0000);

    // sequential writes, then read with held rready
    axi_write("seq1", 32'hA3DD0001, 32'hC2AAEE2A, 4'hF);
    axi_write("seq2", 32'hA3DD0002, 32'h7778111A, 4'hF);
    axi_write("seq3", 32'hA3DD0003, 32'hFE418689, 4'hF);
    araddr_i = 32'hA3DD0001;
    arvalid_i = 1'b1;
    step();
    arvalid_i = 1'b0;
    check("rd_rvalid", rvalid_o, 1);
    check("rd_rdata", rdata_o, 32'hC2AAEE2A);
    check("rd_arready", arready_o, 0);
    repeat (2) begin
      step();
      check("rd_hold_rvalid", rvalid_o, 1);
      check("rd_hold_rdata", rdata_o, 32'hC2AAEE2A);
    end
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("rd_rclr", rvalid_o, 0);
    check("rd_arready_back", arready_o, 1);
    check("rd_rdata_keep", rdata_o, 32'hC2AAEE2A);
    read_chk("seq2_rd", 32'h00000002);
    read_chk("seq3_rd", 32'hFFFFFFF3);

    // byte strobes
    axi_write("strb_a", 32'h5, 32'hFFFFFFFF, 4'hF);
    axi_write("strb_b", 32'h5, 32'h12345678, 4'b1010);
    axi_read(32'h5, d);
    check("strb_rd", d, 32'h12FF56FF);

    // same-cycle addr+data with B stalled, second pair buffered
    awaddr_i = 32'h7;
    wdata_i = 32'h0BADF00D;
    wstrb_i = 4'hF;
    awvalid_i = 1'b1;
    wvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    wvalid_i = 1'b0;
    mdl[7] = 32'h0BADF00D;
    step();
    check("stall_bvalid", bvalid_o, 1);
    awaddr_i = 32'h8;
    wdata_i = 32'h55AA1234;
    awvalid_i = 1'b1;
    wvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    wvalid_i = 1'b0;
    check("stall_awready", awready_o, 0);
    check("stall_wready", wready_o, 0);
    repeat (2) begin
      step();
      check("stall_bhold", bvalid_o, 1);
    end
    read_chk("stall_reg8_old", 32'h8);
    check("stall_bhold2", bvalid_o, 1);
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
    check("stall_bclr", bvalid_o, 0);
    check("stall_aw_still", awready_o, 0);
    step();
    check("stall_commit2", bvalid_o, 1);
    check("stall_awready2", awready_o, 1);
    mdl[8] = 32'h55AA1234;
    b_resp("stall_b2");
    read_chk("stall_reg7", 32'h7);
    read_chk("stall_reg8", 32'h8);

    // read and commit on same index at same edge
    old = mdl[3];
    awaddr_i = 32'h3;
    awvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    wdata_i = 32'h01020304;
    wstrb_i = 4'hF;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    araddr_i = 32'h3;
    arvalid_i = 1'b1;
    step();
    arvalid_i = 1'b0;
    check("same_rvalid", rvalid_o, 1);
    check("same_old", rdata_o, old);
    check("same_bvalid", bvalid_o, 1);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    mdl[3] = 32'h01020304;
    b_resp("same_b");
    read_chk("same_new", 32'h3);

    // random traffic with aliased addresses
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(1) == 1) begin
        axi_write("rnd_wr", $urandom, $urandom, 4'($urandom));
      end else begin
        read_chk("rnd_rd", $urandom);
      end
    end
    for (int i = 0; i < N; i++) read_chk("rnd_sweep", 32'(i));

    // reset mid-transaction
    awaddr_i = 32'h9;
    awvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    areset = 1'b0;
    repeat (2) step();
    check("mrst_awready", awready_o, 0);
    areset = 1'b1;
    step();
    for (int i = 0; i < N; i++) mdl[i] = '0;
    check("mrst_awready_back", awready_o, 1);
    wdata_i = 32'hDEADBEEF;
    wstrb_i = 4'hF;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    repeat (5) begin
      step();
      check("mrst_nocommit", bvalid_o, 0);
    end
    for (int i = 0; i < N; i++) read_chk("mrst_zero", 32'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
